// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, saw/triangle/square/DC shaping
// and mid-scale attenuation, with parameter changes deferred to period wraps.
module dds_wave_gen #(
   parameter int PHASE_W = 32
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               en,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic [1:0]         wave_sel,
   input  logic [4:0]         amplitude,
   output logic [7:0]         dac_data,
   output logic               dac_valid,
   output logic               cycle_start
);

   localparam logic [1:0] SEL_SAW = 2'd0;
   localparam logic [1:0] SEL_TRI = 2'd1;
   localparam logic [1:0] SEL_SQR = 2'd2;

   logic [PHASE_W-1:0] phase;
   logic [PHASE_W:0]   sum;
   logic               wrap_c;
   logic [1:0]         act_sel;
   logic [1:0]         act_shift;
   logic [1:0]         shift_dec;
   logic               wrap_q;
   logic               en_q;

   logic [7:0]         p;
   logic [7:0]         s_nxt;
   logic [7:0]         s_q;
   logic [1:0]         shift_q;
   logic               wrap_s;
   logic               en_s;

   logic signed [7:0]  d;
   logic signed [7:0]  q;

   assign sum    = {1'b0, phase} + {1'b0, freq_word};
   assign wrap_c = en & sum[PHASE_W];

   always_comb begin
      shift_dec = 2'd0;
      case (amplitude)
         5'd2:    shift_dec = 2'd1;
         5'd4:    shift_dec = 2'd2;
         5'd8:    shift_dec = 2'd3;
         default: shift_dec = 2'd0;
      endcase
   end

   // Phase stage; parameters only move at a wrap or while stopped
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         phase     <= '0;
         act_sel   <= SEL_SAW;
         act_shift <= 2'd0;
         wrap_q    <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         if (en) begin
            phase <= sum[PHASE_W-1:0];
         end
         if (wrap_c || !en) begin
            act_sel   <= wave_sel;
            act_shift <= shift_dec;
         end
         wrap_q <= wrap_c;
         en_q   <= en;
      end
   end

   assign p = phase[PHASE_W-1 -: 8];

   always_comb begin
      s_nxt = 8'd128;
      case (act_sel)
         SEL_SAW: s_nxt = p;
         SEL_TRI: s_nxt = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
         SEL_SQR: s_nxt = p[7] ? 8'd0 : 8'd255;
         default: s_nxt = 8'd128;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s_q     <= 8'd128;
         shift_q <= 2'd0;
         wrap_s  <= 1'b0;
         en_s    <= 1'b0;
      end else begin
         if (en_q) begin
            s_q     <= s_nxt;
            shift_q <= act_shift;
         end
         wrap_s <= wrap_q;
         en_s   <= en_q;
      end
   end

   // s - 128 fits in 8 signed bits, so offset-binary flips just the MSB
   assign d = $signed(s_q ^ 8'h80);
   assign q = d >>> shift_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dac_data    <= 8'd128;
         dac_valid   <= 1'b0;
         cycle_start <= 1'b0;
      end else begin
         if (en_s) begin
            dac_data <= q ^ 8'h80;
         end
         dac_valid   <= en_s;
         cycle_start <= wrap_s;
      end
   end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: arithmetic reference model checked every cycle,
// plus directed literal samples from the waveform tables.
module tb_dds_wave_gen;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        en = 1'b0;
   logic [31:0] freq_word = '0;
   logic [1:0]  wave_sel = '0;
   logic [4:0]  amplitude = 5'd1;
   logic [7:0]  dac_data;
   logic        dac_valid;
   logic        cycle_start;

   int n_chk = 0;
   int n_fail = 0;
   int cur = 0;

   dds_wave_gen #(.PHASE_W(32)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .en         (en),
      .freq_word  (freq_word),
      .wave_sel   (wave_sel),
      .amplitude  (amplitude),
      .dac_data   (dac_data),
      .dac_valid  (dac_valid),
      .cycle_start(cycle_start)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit v;
      int d;
      bit c;
   } ent_t;

   ent_t            pipe[$];
   longint unsigned m_phase = 0;
   int              m_sel = 0;
   int              m_shift = 0;
   int              exp_data = 128;
   bit              exp_valid = 0;
   bit              exp_cs = 0;

   function automatic int floor_div(int a, int m);
      if (a >= 0) return a / m;
      return -((-a + m - 1) / m);
   endfunction

   function automatic int model_sample(int pb, int sel, int sh);
      int s;
      case (sel)
         0: s = pb;
         1: s = (pb < 128) ? 2 * pb : 255 - 2 * (pb - 128);
         2: s = (pb < 128) ? 255 : 0;
         default: s = 128;
      endcase
      return floor_div(s - 128, 1 << sh) + 128;
   endfunction

   task automatic model_reset();
      ent_t r;
      r.v = 0;
      r.d = 128;
      r.c = 0;
      m_phase = 0;
      m_sel = 0;
      m_shift = 0;
      exp_data = 128;
      exp_valid = 0;
      exp_cs = 0;
      pipe.delete();
      pipe.push_back(r);
      pipe.push_back(r);
   endtask

   task automatic model_step();
      longint unsigned sum;
      bit   wr;
      ent_t e;
      ent_t n;
      wr = 0;
      if (en) begin
         sum = m_phase + longint'(freq_word);
         wr = (sum >> 32) != 0;
         m_phase = sum & 64'hFFFF_FFFF;
      end
      if (wr || !en) begin
         m_sel = int'(wave_sel);
         m_shift = (amplitude == 2) ? 1 : (amplitude == 4) ? 2 :
                   (amplitude == 8) ? 3 : 0;
      end
      n.v = en;
      n.c = wr;
      n.d = model_sample(int'(m_phase >> 24), m_sel, m_shift);
      e = pipe.pop_front();
      exp_valid = e.v;
      exp_cs = e.c;
      if (e.v) exp_data = e.d;
      pipe.push_back(n);
   endtask

   initial model_reset();

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) model_reset();
      else model_step();
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d",
                  nm, $time, act, exp);
      end
   endtask

   always @(negedge sys_clk) begin
      check("model_data", 32'(dac_data), 32'(exp_data));
      check("model_valid", 32'(dac_valid), 32'(exp_valid));
      check("model_cs", 32'(cycle_start), 32'(exp_cs));
   end

   task automatic start_run(input logic [1:0] ws, input logic [4:0] amp,
                            input logic [31:0] fw);
      @(negedge sys_clk);
      #2 sys_rst_n = 1'b0;
      en = 1'b0;
      wave_sel = ws;
      amplitude = amp;
      freq_word = fw;
      @(negedge sys_clk);
      #2 sys_rst_n = 1'b1;
      @(negedge sys_clk);
      en = 1'b1;
      cur = -1;
   endtask

   task automatic go(input int t);
      repeat (t - cur) @(posedge sys_clk);
      @(negedge sys_clk);
      cur = t;
   endtask

   task automatic chk3(input string nm, input int d, input int v,
                       input int c);
      check({nm, "_data"}, 32'(dac_data), 32'(d));
      check({nm, "_valid"}, 32'(dac_valid), 32'(v));
      check({nm, "_cs"}, 32'(cycle_start), 32'(c));
   endtask

   initial begin
      @(negedge sys_clk);
      chk3("reset", 128, 0, 0);
      #2 sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk3("idle", 128, 0, 0);

      start_run(2'd0, 5'd1, 32'h0100_0000);
      go(1);   chk3("saw_lat", 128, 0, 0);
      go(2);   chk3("saw_first", 1, 1, 0);
      go(256); chk3("saw_255", 255, 1, 0);
      go(257); chk3("saw_wrap", 0, 1, 1);
      go(258); chk3("saw_after", 1, 1, 0);

      start_run(2'd0, 5'd2, 32'h0100_0000);
      go(256); chk3("saw2_255", 191, 1, 0);
      go(257); chk3("saw2_0", 64, 1, 1);

      start_run(2'd0, 5'd8, 32'h0100_0000);
      go(256); chk3("saw8_255", 143, 1, 0);
      go(257); chk3("saw8_0", 112, 1, 1);

      start_run(2'd1, 5'd1, 32'h4000_0000);
      go(2); chk3("tri_64", 128, 1, 0);
      go(3); chk3("tri_128", 255, 1, 0);
      go(4); chk3("tri_192", 127, 1, 0);
      go(5); chk3("tri_0", 0, 1, 1);

      start_run(2'd2, 5'd4, 32'h4000_0000);
      go(2); chk3("sq_lo", 159, 1, 0);
      go(3); chk3("sq_hi", 96, 1, 0);
      go(5); chk3("sq_wrap", 159, 1, 1);

      start_run(2'd3, 5'd1, 32'h4000_0000);
      go(2); chk3("dc_a", 128, 1, 0);
      go(5); chk3("dc_b", 128, 1, 1);

      start_run(2'd0, 5'd1, 32'h4000_0000);
      go(0); amplitude = 5'd8;
      go(3); chk3("bnd_old1", 128, 1, 0);
      go(4); chk3("bnd_old2", 192, 1, 0);
      go(5); chk3("bnd_new", 112, 1, 1);
      go(6); chk3("bnd_new2", 120, 1, 0);
      wave_sel = 2'd2;
      go(8); chk3("bnd_sel_old", 136, 1, 0);
      go(9); chk3("bnd_sel_new", 143, 1, 1);

      start_run(2'd0, 5'd5, 32'h0100_0000);
      go(2);   chk3("ill5_first", 1, 1, 0);
      go(256); chk3("ill5_255", 255, 1, 0);
      start_run(2'd0, 5'd0, 32'h0100_0000);
      go(2);   chk3("ill0_first", 1, 1, 0);

      start_run(2'd0, 5'd1, 32'h0100_0000);
      go(2);  chk3("stall_run", 1, 1, 0);
      freq_word = '0;
      amplitude = 5'd8;
      go(3);  chk3("stall_a", 2, 1, 0);
      go(10); chk3("stall_hold", 3, 1, 0);
      en = 1'b0;
      go(12); chk3("stop_v1", 3, 1, 0);
      go(13); chk3("stop_v0", 3, 0, 0);
      go(19);
      en = 1'b1;
      freq_word = 32'h0100_0000;
      go(21); chk3("resume_lat", 3, 0, 0);
      go(22); chk3("resume_att", 112, 1, 0);

      for (int i = 0; i < 4000; i++) begin
         @(negedge sys_clk);
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) begin
            wave_sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
               0: amplitude = 5'd0;
               1: amplitude = 5'd2;
               2: amplitude = 5'd4;
               3: amplitude = 5'd8;
               4: amplitude = 5'd5;
               5: amplitude = 5'd16;
               default: amplitude = 5'd1;
            endcase
         end
         if ($urandom_range(0, 31) == 0) begin
            case ($urandom_range(0, 3))
               0: freq_word = 32'($urandom);
               1: freq_word = 32'h1 << $urandom_range(20, 31);
               2: freq_word = '0;
               default: freq_word = 32'($urandom_range(1, 255)) << 24;
            endcase
         end
         if ($urandom_range(0, 499) == 0) begin
            #2 sys_rst_n = 1'b0;
            #1 chk3("async_rst", 128, 0, 0);
            @(negedge sys_clk);
            #2 sys_rst_n = 1'b1;
         end
      end

      @(negedge sys_clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
